reg_writeback_ctrl: RTL and testbench

//  Writeback stage feeding the 16x16 register file write port (write_select/write/inputReg).

---
 rtl/reg_writeback_ctrl_pkg.sv | 16 +
 rtl/reg_writeback_ctrl_if.sv | 38 +++
 rtl/reg_writeback_ctrl_sync_fifo.sv | 45 ++++
 rtl/reg_writeback_ctrl.sv | 125 ++++++++++++
 tb/tb_reg_writeback_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared widths and types for the register-file writeback stage.
package reg_writeback_ctrl_pkg;

  localparam int WB_DATA_W    = 16;
  localparam int WB_RADDR_W   = 4;
  localparam int WB_LD_DEPTH  = 4;
  localparam int WB_RSP_DEPTH = 2;

  typedef logic [WB_RADDR_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t              dest;
    logic [WB_DATA_W-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_ctrl_if.sv
// Bundle of ALU, load-issue, load-response, hazard and register-file write signals.
interface reg_writeback_ctrl_if
  import reg_writeback_ctrl_pkg::*;
#(
  parameter int DATA_W  = WB_DATA_W,
  parameter int RADDR_W = WB_RADDR_W
) ();

  logic                    alu_valid;
  logic [RADDR_W-1:0]      alu_dest;
  logic [DATA_W-1:0]       alu_result;
  logic                    ld_issue;
  logic [RADDR_W-1:0]      ld_dest;
  logic                    ld_rsp_valid;
  logic [DATA_W-1:0]       ld_rsp_data;
  logic                    ld_rsp_ready;
  logic [RADDR_W-1:0]      read_select_1;
  logic [RADDR_W-1:0]      read_select_2;
  logic                    hazard_stall;
  logic [2**RADDR_W-1:0]   pending;
  logic                    write;
  logic [RADDR_W-1:0]      write_select;
  logic [DATA_W-1:0]       inputReg;
  logic                    err;

  modport master (
    output alu_valid, alu_dest, alu_result, ld_issue, ld_dest,
           ld_rsp_valid, ld_rsp_data, read_select_1, read_select_2,
    input  ld_rsp_ready, hazard_stall, pending, write, write_select, inputReg, err
  );

  modport slave (
    input  alu_valid, alu_dest, alu_result, ld_issue, ld_dest,
           ld_rsp_valid, ld_rsp_data, read_select_1, read_select_2,
    output ld_rsp_ready, hazard_stall, pending, write, write_select, inputReg, err
  );

endinterface

// File: rtl/reg_writeback_ctrl_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head; pointers carry an extra wrap bit.
module reg_writeback_ctrl_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is data-only; contents behind the pointers are never observed after reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Writeback stage: ALU/load-response arbitration, registered RF write port,
// pending-load scoreboard with decode hazard detection and a sticky protocol error.
module reg_writeback_ctrl
  import reg_writeback_ctrl_pkg::*;
#(
  parameter int DATA_W    = WB_DATA_W,
  parameter int RADDR_W   = WB_RADDR_W,
  parameter int LD_DEPTH  = WB_LD_DEPTH,
  parameter int RSP_DEPTH = WB_RSP_DEPTH
) (
  input logic                 clk,
  input logic                 reset,
  reg_writeback_ctrl_if.slave bus
);

  localparam int NREG  = 2**RADDR_W;
  localparam int ENT_W = RADDR_W + DATA_W;

  typedef struct packed {
    logic [RADDR_W-1:0] dest;
    logic [DATA_W-1:0]  data;
  } entry_t;

  logic               ld_push;
  logic               ld_pop;
  logic               ld_full;
  logic               ld_empty;
  logic [RADDR_W-1:0] ld_head;

  logic               rsp_push;
  logic               rsp_pop;
  logic               rsp_full;
  logic               rsp_empty;
  entry_t             rsp_in;
  entry_t             rsp_head;

  logic [NREG-1:0]    pending_p1;
  logic [NREG-1:0]    pending_next;
  logic               vld_p1;
  logic [RADDR_W-1:0] write_select_p1;
  logic [DATA_W-1:0]  input_reg_p1;
  logic               err_p1;
  logic               err_set;

  // A response is only taken when there is a load to match it with and room to buffer it.
  assign ld_push  = bus.ld_issue & ~ld_full;
  assign rsp_push = bus.ld_rsp_valid & ~rsp_full & ~ld_empty;
  assign ld_pop   = rsp_push;
  assign rsp_pop  = ~bus.alu_valid & ~rsp_empty;
  assign rsp_in   = '{dest: ld_head, data: bus.ld_rsp_data};

  reg_writeback_ctrl_sync_fifo #(
    .WIDTH (RADDR_W),
    .DEPTH (LD_DEPTH)
  ) u_dest_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ld_push),
    .pop   (ld_pop),
    .din   (bus.ld_dest),
    .full  (ld_full),
    .empty (ld_empty),
    .head  (ld_head)
  );

  reg_writeback_ctrl_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rsp_push),
    .pop   (rsp_pop),
    .din   (rsp_in),
    .full  (rsp_full),
    .empty (rsp_empty),
    .head  (rsp_head)
  );

  // Clear before set so a same-register collision leaves the bit set.
  always_comb begin
    pending_next = pending_p1;
    if (rsp_pop) pending_next[rsp_head.dest] = 1'b0;
    if (ld_push) pending_next[bus.ld_dest]   = 1'b1;
  end

  assign err_set = (bus.ld_issue & ld_full)
                 | (bus.ld_rsp_valid & ~rsp_full & ld_empty)
                 | (ld_push & pending_p1[bus.ld_dest])
                 | (bus.alu_valid & pending_p1[bus.alu_dest]);

  // ---- stage p0 -> p1: registered write port, scoreboard and error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1          <= 1'b0;
      write_select_p1 <= '0;
      input_reg_p1    <= '0;
      pending_p1      <= '0;
      err_p1          <= 1'b0;
    end else begin
      vld_p1     <= bus.alu_valid | rsp_pop;
      pending_p1 <= pending_next;
      err_p1     <= err_p1 | err_set;
      if (bus.alu_valid) begin
        write_select_p1 <= bus.alu_dest;
        input_reg_p1    <= bus.alu_result;
      end else if (rsp_pop) begin
        write_select_p1 <= rsp_head.dest;
        input_reg_p1    <= rsp_head.data;
      end
    end
  end

  assign bus.hazard_stall = pending_p1[bus.read_select_1]
                          | pending_p1[bus.read_select_2]
                          | (bus.ld_issue & pending_p1[bus.ld_dest])
                          | ld_full;
  assign bus.ld_rsp_ready = ~rsp_full;
  assign bus.pending      = pending_p1;
  assign bus.write        = vld_p1;
  assign bus.write_select = write_select_p1;
  assign bus.inputReg     = input_reg_p1;
  assign bus.err          = err_p1;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed bench for reg_writeback_ctrl with hand-computed expectations.
module tb_reg_writeback_ctrl;
  import reg_writeback_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  reg_writeback_ctrl_if #(.DATA_W(16), .RADDR_W(4)) bus ();

  reg_writeback_ctrl #(
    .DATA_W    (16),
    .RADDR_W   (4),
    .LD_DEPTH  (4),
    .RSP_DEPTH (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.alu_valid     = 1'b0;
    bus.alu_dest      = '0;
    bus.alu_result    = '0;
    bus.ld_issue      = 1'b0;
    bus.ld_dest       = '0;
    bus.ld_rsp_valid  = 1'b0;
    bus.ld_rsp_data   = '0;
    bus.read_select_1 = '0;
    bus.read_select_2 = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("rst_write",   32'(bus.write),        0);
    chk("rst_wsel",    32'(bus.write_select), 0);
    chk("rst_wdata",   32'(bus.inputReg),     0);
    chk("rst_pending", 32'(bus.pending),      0);
    chk("rst_err",     32'(bus.err),          0);
    chk("rst_ready",   32'(bus.ld_rsp_ready), 1);
    chk("rst_stall",   32'(bus.hazard_stall), 0);
    tick();
    tick();
    reset = 1'b0;

    // ALU-only write
    bus.alu_valid = 1'b1; bus.alu_dest = 4'd3; bus.alu_result = 16'h1234;
    tick();
    bus.alu_valid = 1'b0;
    chk("alu_write", 32'(bus.write),        1);
    chk("alu_wsel",  32'(bus.write_select), 3);
    chk("alu_wdata", 32'(bus.inputReg),     'h1234);
    tick();
    chk("alu_oneshot", 32'(bus.write),      0);
    chk("alu_hold",    32'(bus.inputReg),   'h1234);

    // Single load to r5
    bus.ld_issue = 1'b1; bus.ld_dest = 4'd5;
    #1 chk("ld_issue_nostall", 32'(bus.hazard_stall), 0);
    tick();
    bus.ld_issue = 1'b0;
    chk("ld_pending_set", 32'(bus.pending), 'h0020);
    bus.read_select_1 = 4'd5;
    #1 chk("haz_rs1", 32'(bus.hazard_stall), 1);
    bus.read_select_1 = 4'd0; bus.read_select_2 = 4'd5;
    #1 chk("haz_rs2", 32'(bus.hazard_stall), 1);
    bus.read_select_2 = 4'd0;
    tick();
    tick();
    bus.ld_rsp_valid = 1'b1; bus.ld_rsp_data = 16'hBEEF;
    #1 chk("ld_ready", 32'(bus.ld_rsp_ready), 1);
    tick();
    bus.ld_rsp_valid = 1'b0;
    chk("ld_no_write_yet", 32'(bus.write),   0);
    chk("ld_still_pend",   32'(bus.pending), 'h0020);
    tick();
    chk("ld_write", 32'(bus.write),        1);
    chk("ld_wsel",  32'(bus.write_select), 5);
    chk("ld_wdata", 32'(bus.inputReg),     'hBEEF);
    chk("ld_clear", 32'(bus.pending),      0);
    tick();
    chk("ld_oneshot", 32'(bus.write), 0);

    // Fill the dest FIFO with four loads; a fifth must stall
    for (int i = 1; i <= 4; i++) begin
      bus.ld_issue = 1'b1; bus.ld_dest = 4'(i);
      tick();
    end
    chk("four_pending", 32'(bus.pending), 'h001E);
    bus.ld_dest = 4'd6;
    #1 chk("fifth_stall", 32'(bus.hazard_stall), 1);
    bus.ld_issue = 1'b0;
    #1 chk("full_stall", 32'(bus.hazard_stall), 1);
    for (int i = 0; i < 4; i++) begin
      bus.ld_rsp_valid = 1'b1; bus.ld_rsp_data = 16'hA001 + 16'(i);
      tick();
    end
    chk("drain_wsel3",  32'(bus.write_select), 3);
    chk("drain_wdata3", 32'(bus.inputReg),     'hA003);
    chk("drain_pend",   32'(bus.pending),      'h0010);
    bus.ld_rsp_valid = 1'b0;
    tick();
    chk("drain_wsel4",  32'(bus.write_select), 4);
    chk("drain_wdata4", 32'(bus.inputReg),     'hA004);
    chk("drain_empty",  32'(bus.pending),      0);
    chk("drain_nostall", 32'(bus.hazard_stall), 0);

    // Three responses under continuous ALU pressure
    for (int i = 8; i <= 10; i++) begin
      bus.ld_issue = 1'b1; bus.ld_dest = 4'(i);
      tick();
    end
    bus.ld_issue = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_dest = 4'd11; bus.alu_result = 16'h1111;
    bus.ld_rsp_valid = 1'b1; bus.ld_rsp_data = 16'hC008;
    #1 chk("col_ready0", 32'(bus.ld_rsp_ready), 1);
    tick();
    chk("col_alu_wsel", 32'(bus.write_select), 11);
    chk("col_alu_data", 32'(bus.inputReg),     'h1111);
    chk("col_ready1",   32'(bus.ld_rsp_ready), 1);
    bus.ld_rsp_data = 16'hC009;
    tick();
    chk("col_full", 32'(bus.ld_rsp_ready), 0);
    bus.ld_rsp_data = 16'hC00A;
    tick();
    chk("col_full2", 32'(bus.ld_rsp_ready), 0);
    chk("col_alu3",  32'(bus.write_select), 11);
    tick();
    chk("col_full3",  32'(bus.ld_rsp_ready), 0);
    chk("col_pend",   32'(bus.pending),      'h0700);
    bus.alu_valid = 1'b0;
    tick();
    chk("col_ld8_write", 32'(bus.write),        1);
    chk("col_ld8_wsel",  32'(bus.write_select), 8);
    chk("col_ld8_data",  32'(bus.inputReg),     'hC008);
    chk("col_ld8_pend",  32'(bus.pending),      'h0600);
    chk("col_ready_back", 32'(bus.ld_rsp_ready), 1);
    tick();
    bus.ld_rsp_valid = 1'b0;
    chk("col_ld9_wsel", 32'(bus.write_select), 9);
    chk("col_ld9_data", 32'(bus.inputReg),     'hC009);
    chk("col_ld9_pend", 32'(bus.pending),      'h0400);
    tick();
    chk("col_ld10_wsel", 32'(bus.write_select), 10);
    chk("col_ld10_data", 32'(bus.inputReg),     'hC00A);
    chk("col_ld10_pend", 32'(bus.pending),      0);
    tick();
    chk("col_idle",  32'(bus.write), 0);
    chk("col_noerr", 32'(bus.err),   0);

    // Response with no outstanding load
    bus.ld_rsp_valid = 1'b1; bus.ld_rsp_data = 16'hDEAD;
    tick();
    bus.ld_rsp_valid = 1'b0;
    chk("orphan_err",     32'(bus.err),     1);
    chk("orphan_nowrite", 32'(bus.write),   0);
    chk("orphan_pend",    32'(bus.pending), 0);
    tick();
    tick();
    chk("orphan_sticky", 32'(bus.err),   0 + 1);
    chk("orphan_nowrite2", 32'(bus.write), 0);

    // Reset clears err; then reset mid-operation
    reset = 1'b1;
    #1 chk("rst_clears_err", 32'(bus.err), 0);
    reset = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      bus.ld_issue = 1'b1; bus.ld_dest = 4'(i);
      tick();
    end
    bus.ld_issue = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_dest = 4'd12; bus.alu_result = 16'h5A5A;
    bus.ld_rsp_valid = 1'b1; bus.ld_rsp_data = 16'hE002;
    tick();
    chk("mid_pend", 32'(bus.pending),      'h001C);
    chk("mid_wsel", 32'(bus.write_select), 12);
    bus.alu_valid = 1'b0; bus.ld_rsp_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_write", 32'(bus.write),        0);
    chk("mid_rst_wsel",  32'(bus.write_select), 0);
    chk("mid_rst_data",  32'(bus.inputReg),     0);
    chk("mid_rst_pend",  32'(bus.pending),      0);
    chk("mid_rst_ready", 32'(bus.ld_rsp_ready), 1);
    chk("mid_rst_stall", 32'(bus.hazard_stall), 0);
    reset = 1'b0;
    tick();
    chk("mid_flushed", 32'(bus.write), 0);

    // ALU write to a register with a load outstanding
    bus.ld_issue = 1'b1; bus.ld_dest = 4'd6;
    tick();
    bus.ld_issue = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_dest = 4'd6; bus.alu_result = 16'h7777;
    tick();
    bus.alu_valid = 1'b0;
    chk("waw_err",   32'(bus.err),          1);
    chk("waw_write", 32'(bus.write),        1);
    chk("waw_wsel",  32'(bus.write_select), 6);
    chk("waw_data",  32'(bus.inputReg),     'h7777);
    chk("waw_pend",  32'(bus.pending),      'h0040);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
